// File: rtl/trig_capture_ram_pkg.sv
// Shared definitions for the trigger capture RAM.
//   DW_DEF / AW_DEF : default sample width and address width
//   state_t         : 3-bit capture state encoding, also used by the MCU register decode
package trig_capture_ram_pkg;

   localparam int DW_DEF = 18;
   localparam int AW_DEF = 12;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE   = 3'd1,
      ST_ARMED = 3'd2,
      ST_POST  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/trig_capture_ram_if.sv
// Control, sample and read-out signals of the trigger capture RAM.
//   master : driven by the ADC/MCU side (Start, Wen, Din, Trig, PreDepth, Rd_En, Raddr)
//   slave  : the capture RAM (Dout, Dout_Vld, State, Trig_Addr, Done)
interface trig_capture_ram_if
   import trig_capture_ram_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
);
   logic          Start;
   logic          Wen;
   logic [DW-1:0] Din;
   logic          Trig;
   logic [AW-1:0] PreDepth;
   logic          Rd_En;
   logic [AW-1:0] Raddr;
   logic [DW-1:0] Dout;
   logic          Dout_Vld;
   logic [2:0]    State;
   logic [AW-1:0] Trig_Addr;
   logic          Done;

   modport master (
      output Start, Wen, Din, Trig, PreDepth, Rd_En, Raddr,
      input  Dout, Dout_Vld, State, Trig_Addr, Done
   );

   modport slave (
      input  Start, Wen, Din, Trig, PreDepth, Rd_En, Raddr,
      output Dout, Dout_Vld, State, Trig_Addr, Done
   );
endinterface

// File: rtl/trig_capture_ram_sp_capture_mem.sv
// DEPTH x DW sample memory: one synchronous write port and one registered read port.
//   wclk  : clock for both ports
//   rst_n : async active-low reset of the read data register only (array is not reset)
//   we / waddr / wdata : write port
//   re / raddr / rdata : read port, rdata updates one cycle after re and holds otherwise
// A read and write of the same address in one cycle returns the old contents.
module sp_capture_mem #(
   parameter int DW = 18,
   parameter int AW = 12
) (
   input  logic          wclk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);
   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge wclk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge wclk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/trig_capture_ram.sv
// Circular capture buffer with trigger positioning.
//   Clk  : system clock (rising edge)
//   nRst : async active-low reset
//   bus  : capture control, sample stream, read-out and status (see trig_capture_ram_if)
// A capture keeps PreDepth samples before the trigger sample and fills the remaining
// DEPTH-1-PreDepth words after it, so exactly DEPTH samples are held when Done rises.
// Read offsets are relative to the oldest captured sample.
module trig_capture_ram
   import trig_capture_ram_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic                Clk,
   input  logic                nRst,
   trig_capture_ram_if.slave   bus
);
   localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

   state_t        state, state_nx;
   logic [AW-1:0] wptr;
   logic [AW-1:0] pre_cnt;
   logic [AW-1:0] pre_r;
   logic [AW-1:0] post_cnt;
   logic [AW-1:0] trig_addr;
   logic          dout_vld;
   logic          we;
   logic          trig_hit;
   logic [AW-1:0] rd_addr;

   // Start outranks Wen/Trig: a sample arriving with Start is dropped.
   always_comb begin
      state_nx = state;
      we       = 1'b0;
      trig_hit = 1'b0;
      if (bus.Start) begin
         state_nx = (bus.PreDepth == '0) ? ST_ARMED : ST_PRE;
      end else if (bus.Wen) begin
         unique case (state)
            ST_PRE: begin
               we = 1'b1;
               if (pre_cnt + ONE == pre_r) state_nx = ST_ARMED;
            end
            ST_ARMED: begin
               we = 1'b1;
               if (bus.Trig) begin
                  trig_hit = 1'b1;
                  // ~pre_r is DEPTH-1-pre_r; zero means the trigger filled the buffer
                  state_nx = (~pre_r == '0) ? ST_DONE : ST_POST;
               end
            end
            ST_POST: begin
               we = 1'b1;
               if (post_cnt == ONE) state_nx = ST_DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         wptr      <= '0;
         pre_cnt   <= '0;
         pre_r     <= '0;
         post_cnt  <= '0;
         trig_addr <= '0;
      end else if (bus.Start) begin
         wptr    <= '0;
         pre_cnt <= '0;
         pre_r   <= bus.PreDepth;
      end else if (we) begin
         wptr <= wptr + ONE;
         if (state == ST_PRE) pre_cnt <= pre_cnt + ONE;
         if (trig_hit) begin
            trig_addr <= wptr;
            post_cnt  <= ~pre_r;
         end
         if (state == ST_POST) post_cnt <= post_cnt - ONE;
      end
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) dout_vld <= 1'b0;
      else       dout_vld <= bus.Rd_En;
   end

   // AW-bit arithmetic wraps modulo DEPTH
   assign rd_addr = trig_addr - pre_r + bus.Raddr;

   sp_capture_mem #(
      .DW (DW),
      .AW (AW)
   ) u_mem (
      .wclk  (Clk),
      .rst_n (nRst),
      .we    (we),
      .waddr (wptr),
      .wdata (bus.Din),
      .re    (bus.Rd_En),
      .raddr (rd_addr),
      .rdata (bus.Dout)
   );

   assign bus.Dout_Vld  = dout_vld;
   assign bus.State     = state;
   assign bus.Trig_Addr = trig_addr;
   assign bus.Done      = (state == ST_DONE);
endmodule

// File: tb/tb_trig_capture_ram.sv
// Directed bench for trig_capture_ram at AW=4 (DEPTH=16), DW=18.
module tb_trig_capture_ram;
   localparam int DW = 18;
   localparam int AW = 4;

   logic Clk;
   logic nRst;
   int   tests;
   int   fails;
   logic [DW-1:0] exp_q[$];

   trig_capture_ram_if #(.DW(DW), .AW(AW)) cap_if ();

   trig_capture_ram #(.DW(DW), .AW(AW)) dut (
      .Clk  (Clk),
      .nRst (nRst),
      .bus  (cap_if)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the edge and retire any read result.
   task automatic step();
      logic [DW-1:0] e;
      @(posedge Clk);
      #1;
      if (cap_if.Dout_Vld === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_dout_vld", 32'(cap_if.Dout_Vld), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("dout", 32'(cap_if.Dout), 32'(e));
         end
      end
   endtask

   task automatic wr(input int v, input logic t);
      cap_if.Wen  = 1'b1;
      cap_if.Din  = DW'(v);
      cap_if.Trig = t;
      step();
      cap_if.Wen  = 1'b0;
      cap_if.Trig = 1'b0;
   endtask

   task automatic rd(input int offs, input int exp);
      cap_if.Rd_En = 1'b1;
      cap_if.Raddr = AW'(offs);
      exp_q.push_back(DW'(exp));
      step();
      cap_if.Rd_En = 1'b0;
   endtask

   task automatic arm(input int pre);
      cap_if.PreDepth = AW'(pre);
      cap_if.Start    = 1'b1;
      step();
      cap_if.Start    = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      nRst  = 1'b0;
      cap_if.Start = 1'b0; cap_if.Wen = 1'b0; cap_if.Din = '0; cap_if.Trig = 1'b0;
      cap_if.PreDepth = '0; cap_if.Rd_En = 1'b0; cap_if.Raddr = '0;
      #1;
      chk("rst_state", 32'(cap_if.State), 32'd0);
      chk("rst_done", 32'(cap_if.Done), 32'd0);
      chk("rst_dout", 32'(cap_if.Dout), 32'd0);
      chk("rst_vld", 32'(cap_if.Dout_Vld), 32'd0);
      chk("rst_trig_addr", 32'(cap_if.Trig_Addr), 32'd0);
      step();
      step();
      nRst = 1'b1;
      step();

      // PreDepth=4, trigger on sample 10
      arm(4);
      chk("t1_state_pre", 32'(cap_if.State), 32'd1);
      for (int v = 1; v <= 21; v++) begin
         wr(v, v == 10);
         if (v == 3)  chk("t1_pre_at3", 32'(cap_if.State), 32'd1);
         if (v == 4)  chk("t1_armed_at4", 32'(cap_if.State), 32'd2);
         if (v == 9)  chk("t1_armed_at9", 32'(cap_if.State), 32'd2);
         if (v == 10) begin
            chk("t1_post_at10", 32'(cap_if.State), 32'd3);
            chk("t1_trig_addr", 32'(cap_if.Trig_Addr), 32'd9);
         end
         if (v == 20) chk("t1_notdone_at20", 32'(cap_if.Done), 32'd0);
         if (v == 21) begin
            chk("t1_done_state", 32'(cap_if.State), 32'd4);
            chk("t1_done", 32'(cap_if.Done), 32'd1);
         end
      end
      for (int v = 200; v < 204; v++) wr(v, 1'b1);
      chk("t1_done_hold", 32'(cap_if.State), 32'd4);
      step();
      rd(0, 6);
      rd(4, 10);
      rd(15, 21);
      step();
      step();
      chk("t1_dout_hold", 32'(cap_if.Dout), 32'd21);
      chk("t1_vld_low", 32'(cap_if.Dout_Vld), 32'd0);

      // Trig held through PRE is ignored
      arm(4);
      for (int v = 1; v <= 4; v++) wr(v, 1'b1);
      chk("t3_armed", 32'(cap_if.State), 32'd2);
      chk("t3_no_early_trig", 32'(cap_if.Trig_Addr), 32'd9);
      wr(5, 1'b1);
      chk("t3_post", 32'(cap_if.State), 32'd3);
      chk("t3_trig_addr", 32'(cap_if.Trig_Addr), 32'd4);

      // PreDepth=0
      arm(0);
      chk("t4_armed", 32'(cap_if.State), 32'd2);
      for (int v = 1; v <= 16; v++) begin
         wr(v, v == 1);
         if (v == 1)  chk("t4_trig_addr", 32'(cap_if.Trig_Addr), 32'd0);
         if (v == 15) chk("t4_post_at15", 32'(cap_if.State), 32'd3);
         if (v == 16) chk("t4_done", 32'(cap_if.Done), 32'd1);
      end
      rd(0, 1);
      rd(5, 6);

      // PreDepth=15: trigger is the last sample
      arm(15);
      for (int v = 1; v <= 15; v++) wr(v, 1'b0);
      chk("t5_armed", 32'(cap_if.State), 32'd2);
      wr(16, 1'b1);
      chk("t5_direct_done", 32'(cap_if.State), 32'd4);
      chk("t5_trig_addr", 32'(cap_if.Trig_Addr), 32'd15);
      rd(15, 16);
      rd(0, 1);
      rd(7, 8);
      step();

      // Reset mid-POST
      arm(4);
      for (int v = 1; v <= 10; v++) wr(v, v == 6);
      chk("t6_in_post", 32'(cap_if.State), 32'd3);
      #3;
      nRst = 1'b0;
      #1;
      chk("t6_rst_state", 32'(cap_if.State), 32'd0);
      chk("t6_rst_done", 32'(cap_if.Done), 32'd0);
      chk("t6_rst_dout", 32'(cap_if.Dout), 32'd0);
      chk("t6_rst_trig_addr", 32'(cap_if.Trig_Addr), 32'd0);
      step();
      nRst = 1'b1;
      step();

      // Start with Wen in the same cycle drops the sample
      cap_if.PreDepth = '0;
      cap_if.Start    = 1'b1;
      cap_if.Wen      = 1'b1;
      cap_if.Din      = DW'(77);
      step();
      cap_if.Start = 1'b0;
      cap_if.Wen   = 1'b0;
      chk("t6_start_armed", 32'(cap_if.State), 32'd2);
      wr(100, 1'b1);
      chk("t6_wptr_zero", 32'(cap_if.Trig_Addr), 32'd0);
      rd(0, 100);
      step();
      step();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      fails++;
      $display("FAIL timeout: observed running expected finished");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/trig_capture_ram.md
Name: trig_capture_ram

Overview:
- Parametrised successor to the 4096x18 sample RAM.
- A single-clock circular capture buffer with built-in trigger positioning.
- Samples stream in continuously; a programmable pre-trigger depth is retained, post-trigger filling stops automatically, and read-back is addressed relative to the oldest captured sample.
- Sits between the ADC sample path and the MCU read-out interface.

Parameters:
- DW, 18, sample word width (bits)
- AW, 12, address width; DEPTH = 2**AW words

Ports:
- Clk  input  1  system clock, all logic on rising edge
- nRst  input  1  asynchronous active-low reset
- Start  input  1  one-cycle pulse: (re)arm a capture
- Wen  input  1  sample strobe; Din valid this cycle
- Din  input  DW  sample data
- Trig  input  1  trigger qualifier, sampled only with Wen
- PreDepth  input  AW  samples kept before the trigger sample; sampled on Start
- Rd_En  input  1  read request
- Raddr  input  AW  read offset from the oldest captured sample
- Dout  output  DW  read data
- Dout_Vld  output  1  Dout valid
- State  output  3  0 IDLE, 1 PRE, 2 ARMED, 3 POST, 4 DONE
- Trig_Addr  output  AW  physical address of the trigger sample
- Done  output  1  capture complete (equals State==DONE)

Behaviour:
- Reset (async, nRst=0):
  - State=IDLE; Wptr, counters, Trig_Addr, Dout and Dout_Vld = 0; Done=0.
  - Memory contents are not reset.
- Start, in any state, next edge:
  - Wptr<=0, PreCnt<=0, latch PreDepth into Pre_r, Done<=0.
  - State<=PRE, or ARMED if PreDepth==0.
  - Start outranks Wen and Trig in the same cycle; that sample is discarded and not written.
- IDLE, DONE: Wen is ignored and nothing is written.
- PRE:
  - Each Wen writes Din at Wptr; Wptr<=Wptr+1 modulo DEPTH; PreCnt++.
  - When PreCnt+1==Pre_r on a Wen cycle, go to ARMED on that edge.
  - Trig is ignored in PRE.
- ARMED:
  - Each Wen writes and advances Wptr.
  - Wen&Trig: that sample is the trigger sample. Trig_Addr<=Wptr; PostCnt<=DEPTH-1-Pre_r.
  - Next state is POST, or DONE directly if DEPTH-1-Pre_r==0.
- POST:
  - Each Wen writes, advances Wptr and decrements PostCnt.
  - The write that brings PostCnt to 0 sets State<=DONE and Done<=1 on the same edge.
  - Total capture is always exactly DEPTH samples: the oldest is at Trig_Addr-Pre_r (mod DEPTH), the newest is at Trig_Addr+DEPTH-1-Pre_r.
- Pre_r greater than DEPTH-1 is impossible by width: at PreDepth=DEPTH-1 the trigger sample is the last sample.
- Read path:
  - Allowed in every state.
  - Physical address = Trig_Addr - Pre_r + Raddr, modulo DEPTH; arithmetic is AW bits wide and wraps naturally.
  - Dout is registered with 1-cycle latency. Dout_Vld is Rd_En delayed by 1 cycle.
  - Dout holds its last value when Rd_En=0.
  - Read and write to the same physical address in one cycle returns the old data (read-before-write).
  - Before any trigger, Trig_Addr is 0 or stale, and reads map accordingly; no protection is provided.
- Reset mid-capture: returns to IDLE immediately; Done=0; memory keeps partial data.

Decomposition:
- Shared package holds:
  - State encodings ST_IDLE..ST_DONE (3-bit), shared by the MCU register decode.
  - DW/AW default constants.
- One sub-module, sp_capture_mem: a DEPTH x DW array with one synchronous write port and one registered synchronous read port on Clk.
- The control FSM, pointers and address arithmetic stay in trig_capture_ram.

Test Plan (bench uses AW=4, DEPTH=16, DW=18; sample values written as 1,2,3,...):
- PreDepth=4, Start, stream; Trig with value 10 → Trig_Addr=9, State 1→2 after value 4, 2→3 at value 10, Done=1 after value 21 (11 post samples); further Wen leaves memory unchanged.
- After the previous capture, read Raddr=0,4,15 → Dout=6,10,21 each one cycle after Rd_En, with Dout_Vld=1 for exactly those cycles.
- Trig held high throughout PRE with PreDepth=4 → no trigger before value 5; trigger taken on value 5, Trig_Addr=4.
- PreDepth=0: Start → State=ARMED next cycle; Trig with value 1 → Trig_Addr=0, Done after value 16; Raddr=0 → Dout=1.
- PreDepth=15, trigger on value 16 → State goes ARMED→DONE directly; Raddr=15 → 16, Raddr=0 → 1.
- nRst pulsed mid-POST → State=0, Done=0, Dout=0 asynchronously. Start with Wen in the same cycle → sample not written, Wptr=0.
